hamming_block_decoder: RTL and testbench
========================================

# hamming_block_decoder

Parametrised, multi-lane Hamming SEC decoder for the PUF key-reconstruction path. It takes a frame of `NBLK` noisy response blocks plus their helper-data parity bits and decodes `LANES` blocks per cycle under a start/busy/done handshake. Each block's single-bit errors are corrected, and the block reports how many blocks needed correction. It sits between the PUF response capture and the key-derivation stage, and handles any Hamming(2^R−1, 2^R−1−R) code.

## Interface
- `R`, 4, parity bits per block; `N = 2^R−1` codeword bits; `K = N−R` data bits per block (11 by default)
- `NBLK`, 24, blocks per frame; must be a multiple of `LANES`
- `LANES`, 1, blocks decoded per cycle; `G = NBLK/LANES` groups per frame
- `CW`, `$clog2(NBLK+1)`, error-count width (derived)

Ports:
- `clk` in 1: clock, rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: frame request, sampled in IDLE only
- `i_data` in NBLK*K: noisy data; block b = `i_data[b*K +: K]`
- `i_helper` in NBLK*R: helper parity; block b = `i_helper[b*R +: R]`
- `busy` out 1: high while decoding
- `done` out 1: one-cycle pulse, frame result valid
- `o_data` out NBLK*K: corrected data, same packing as `i_data`
- `o_err_cnt` out CW: number of blocks with a nonzero syndrome
- `o_err_map` out NBLK: per-block error flags (see Configuration)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on `start`:
  - capture `i_data` and `i_helper` into internal frame registers;
  - clear the group counter, `o_err_cnt` and `o_err_map`.
  - Inputs are don't-care after the capture cycle.
- RUN, cycle g (g = 0..G−1): decode blocks g*LANES .. g*LANES+LANES−1 and write the results into `o_data`.
  - RUN → DONE after g = G−1.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- Codeword assembly, positions 1..N:
  - helper bit j sits at position 2^j;
  - data bits fill the remaining positions in ascending order, so data bit 0 is at position 3.
- Syndrome bit j = XOR of all codeword bits at positions p with p[j] = 1. A nonzero syndrome s flips position s.
  - If s is a power of two, only a parity bit was wrong: data passes through unchanged, but the block still counts as an error.
- `o_err_cnt` += number of lanes in the group with a nonzero syndrome. It cannot overflow: its maximum is NBLK.
- Double-bit errors are not detected. They are miscorrected per the syndrome; this is accepted behaviour.
- `o_data` blocks not yet processed in the current frame keep their previous-frame values. The whole of `o_data` is valid at `done` and holds until the next frame writes it.
- `start` while in RUN or DONE is ignored; it is not queued.

## Timing
- Reset values: state IDLE, `busy` = 0, `done` = 0, `o_data` = 0, `o_err_cnt` = 0, `o_err_map` = 0, group counter = 0.
- `start` sampled high in cycle T:
  - `busy` = 1 in cycles T+1 .. T+G;
  - `done` = 1 and `busy` = 0 in cycle T+G+1.
- Default latency is 25 cycles from `start` to `done`. With LANES = 4 it is 7 cycles.
- `start` can be accepted in the cycle after `done` (back-to-back frames); this costs G+2 cycles per frame.
- `reset` during RUN or DONE: all outputs return to their reset values in the next cycle, the frame is abandoned, and no `done` is issued.
- Decode is combinational within one cycle per group; results are registered on the RUN edge. There are no negedge processes.

## Configuration
- `HAMMING_DEC_ERRMAP_EN`
  - Defined: bit b of `o_err_map` is set when block b's syndrome is nonzero; the map is cleared at frame capture and valid at `done`.
  - Undefined: no map registers are built, and `o_err_map` is tied to 0.
- `o_err_cnt` is unaffected by this macro.

## Test plan
- Clean frame:
  - Stimulus: all zeros, helper all zeros, `start` in cycle 0.
  - Response: `done` in cycle 25, `o_data` = 0, `o_err_cnt` = 0, `busy` high in cycles 1–24.
- Single data-bit error:
  - Stimulus: every block 0x7FF with helper 0xF (a valid codeword), except block 5 data = 0x7EF.
  - Response: `o_data` all blocks 0x7FF, `o_err_cnt` = 1, `o_err_map` = 1<<5 (macro defined).
- Parity-only error:
  - Stimulus: block 0 helper = 0xB (bit 2 flipped), data 0x7FF.
  - Response: block 0 output = 0x7FF, `o_err_cnt` = 1.
- Every block erroneous:
  - Stimulus: each block 0x7FF/0xF with one distinct data bit flipped.
  - Response: all blocks 0x7FF, `o_err_cnt` = 24, `o_err_map` all ones.
- Handshake and reset:
  - Stimulus: `start` pulsed again in cycle 10.
  - Response: ignored, single `done` in cycle 25.
  - Stimulus: separate run with `reset` in cycle 12.
  - Response: outputs 0 in cycle 13, no `done`.
- LANES = 4, NBLK = 24:
  - Stimulus: the error frame from the single-data-bit-error test.
  - Response: `done` in cycle 7 with identical results.

Source files
------------

// File: rtl/hamming_block_decoder.sv
// hamming_block_decoder: multi-lane Hamming SEC decoder for PUF helper-data frames.
// Optional per-block error map enabled by HAMMING_DEC_ERRMAP_EN.
module hamming_block_decoder #(
   parameter int R     = 4,
   parameter int NBLK  = 24,
   parameter int LANES = 1,
   parameter int CW    = $clog2(NBLK + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [NBLK*(2**R-1-R)-1:0] i_data,
   input  logic [NBLK*R-1:0]       i_helper,
   output logic                    busy,
   output logic                    done,
   output logic [NBLK*(2**R-1-R)-1:0] o_data,
   output logic [CW-1:0]           o_err_cnt,
   output logic [NBLK-1:0]         o_err_map
);
   localparam int N  = 2**R - 1;
   localparam int K  = N - R;
   localparam int G  = NBLK / LANES;
   localparam int GW = (G > 1) ? $clog2(G) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nx;
   logic [GW-1:0]     grp;
   logic [NBLK*K-1:0] frm_data;
   logic [NBLK*R-1:0] frm_helper;
   logic [LANES*K-1:0] lane_data;
   logic [LANES-1:0]  lane_err;
   logic [CW-1:0]     lane_cnt;

   // Helper bit j lives at position 2^j; data bits fill the other positions in order.
   function automatic logic [K:0] decode(input logic [K-1:0] d, input logic [R-1:0] h);
      logic [R-1:0] s;
      logic [K-1:0] c;
      int j, di;
      s = '0;
      j = 0;
      di = 0;
      for (int p = 1; p <= N; p++) begin
         if ((p & (p - 1)) == 0) begin
            if (h[j]) s = s ^ R'(p);
            j++;
         end else begin
            if (d[di]) s = s ^ R'(p);
            di++;
         end
      end
      c = d;
      di = 0;
      for (int p = 1; p <= N; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (s == R'(p)) c[di] = ~d[di];
            di++;
         end
      end
      return {s != '0, c};
   endfunction

   always_comb begin
      lane_data = '0;
      lane_err  = '0;
      lane_cnt  = '0;
      for (int l = 0; l < LANES; l++) begin
         {lane_err[l], lane_data[l*K +: K]} = decode(frm_data[(int'(grp)*LANES + l)*K +: K],
                                                     frm_helper[(int'(grp)*LANES + l)*R +: R]);
         lane_cnt = lane_cnt + CW'(lane_err[l]);
      end
   end

   always_ff @(posedge clk)
      state <= reset ? IDLE : state_nx;

   always_comb begin
      state_nx = (state == IDLE) ? (start ? RUN : IDLE) :
                 (state == RUN)  ? ((grp == GW'(G - 1)) ? DONE : RUN) : IDLE;
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         grp        <= '0;
         frm_data   <= '0;
         frm_helper <= '0;
         o_data     <= '0;
         o_err_cnt  <= '0;
      end else if (state == IDLE && start) begin
         grp        <= '0;
         frm_data   <= i_data;
         frm_helper <= i_helper;
         o_err_cnt  <= '0;
      end else if (state == RUN) begin
         grp       <= grp + GW'(1);
         o_err_cnt <= o_err_cnt + lane_cnt;
         for (int l = 0; l < LANES; l++)
            o_data[(int'(grp)*LANES + l)*K +: K] <= lane_data[l*K +: K];
      end
   end

`ifdef HAMMING_DEC_ERRMAP_EN
   always_ff @(posedge clk) begin
      if (reset || (state == IDLE && start))
         o_err_map <= '0;
      else if (state == RUN)
         for (int l = 0; l < LANES; l++)
            if (lane_err[l]) o_err_map[int'(grp)*LANES + l] <= 1'b1;
   end
`else
   assign o_err_map = '0;
`endif

endmodule

// File: tb/tb_hamming_block_decoder.sv
// tb_hamming_block_decoder: scoreboard bench for hamming_block_decoder, LANES=1 and LANES=4.
module tb_hamming_block_decoder;
   localparam int R = 4, K = 11, NBLK = 24, CW = 5, G1 = 24, G4 = 6;
   localparam int W = NBLK * K;

   typedef struct {
      logic [W-1:0]    data;
      int              cnt;
      logic [NBLK-1:0] map;
      int              tdone;
      int              nbusy;
   } exp_t;

   logic clk = 0, reset = 1, start1 = 0, start4 = 0;
   logic [W-1:0] din = '0, od1, od4;
   logic [NBLK*R-1:0] hin = '0;
   logic busy1, done1, busy4, done4;
   logic [CW-1:0] cnt1, cnt4;
   logic [NBLK-1:0] map1, map4;

   exp_t q1[$], q4[$];
   exp_t e1, e4;
   int cyc = 0, ncmp = 0, nfail = 0, bc1 = 0, bc4 = 0;
   logic [W-1:0] fd, fe;
   logic [NBLK*R-1:0] fh;
   logic [NBLK-1:0] fm;

   hamming_block_decoder #(.R(R), .NBLK(NBLK), .LANES(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .i_data(din), .i_helper(hin),
      .busy(busy1), .done(done1), .o_data(od1), .o_err_cnt(cnt1), .o_err_map(map1));

   hamming_block_decoder #(.R(R), .NBLK(NBLK), .LANES(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .i_data(din), .i_helper(hin),
      .busy(busy4), .done(done4), .o_data(od4), .o_err_cnt(cnt4), .o_err_map(map4));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rep_d(input logic [K-1:0] v);
      logic [W-1:0] r;
      for (int b = 0; b < NBLK; b++) r[b*K +: K] = v;
      return r;
   endfunction

   function automatic logic [NBLK*R-1:0] rep_h(input logic [R-1:0] v);
      logic [NBLK*R-1:0] r;
      for (int b = 0; b < NBLK; b++) r[b*R +: R] = v;
      return r;
   endfunction

   always @(negedge clk) begin
      if (reset) bc1 = 0;
      else begin
         if (busy1) bc1++;
         if (done1) begin
            if (q1.size() == 0) begin
               ncmp++; nfail++;
               $display("FAIL unexpected_done_l1: got done at cycle %0d expected none", cyc);
            end else begin
               e1 = q1.pop_front();
               cmp("latency_l1", cyc, e1.tdone);
               cmp("busy_cycles_l1", bc1, e1.nbusy);
               cmp("data_l1", od1, e1.data);
               cmp("err_cnt_l1", cnt1, e1.cnt);
               cmp("err_map_l1", map1, e1.map);
            end
            bc1 = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (reset) bc4 = 0;
      else begin
         if (busy4) bc4++;
         if (done4) begin
            if (q4.size() == 0) begin
               ncmp++; nfail++;
               $display("FAIL unexpected_done_l4: got done at cycle %0d expected none", cyc);
            end else begin
               e4 = q4.pop_front();
               cmp("latency_l4", cyc, e4.tdone);
               cmp("busy_cycles_l4", bc4, e4.nbusy);
               cmp("data_l4", od4, e4.data);
               cmp("err_cnt_l4", cnt4, e4.cnt);
               cmp("err_map_l4", map4, e4.map);
            end
            bc4 = 0;
         end
      end
   end

   // Called at a negedge; returns at the negedge of the cycle after done.
   task automatic frame(input bit four, input logic [W-1:0] d, input logic [NBLK*R-1:0] h,
                        input logic [W-1:0] ed, input int cnt, input logic [NBLK-1:0] map,
                        input bit pulse);
      exp_t e;
      bit seen;
      int g;
      g = four ? G4 : G1;
      din = d;
      hin = h;
      e.data = ed;
      e.cnt = cnt;
`ifdef HAMMING_DEC_ERRMAP_EN
      e.map = map;
`else
      e.map = '0;
`endif
      e.tdone = cyc + 1 + g;
      e.nbusy = g;
      if (four) begin start4 = 1; q4.push_back(e); end
      else begin start1 = 1; q1.push_back(e); end
      @(negedge clk);
      start1 = 0;
      start4 = 0;
      din = ~din;
      hin = ~hin;
      if (pulse) begin
         repeat (9) @(negedge clk);
         start1 = 1;
         @(negedge clk);
         start1 = 0;
      end
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (four ? done4 : done1) seen = 1;
         else @(negedge clk);
      end
      if (!seen) begin
         ncmp++; nfail++;
         $display("FAIL done_timeout: got no done within 100 cycles expected done");
         q1.delete();
         q4.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 0;
      cmp("reset_busy", busy1, 0);
      cmp("reset_done", done1, 0);
      cmp("reset_data", od1, 0);
      cmp("reset_cnt", cnt1, 0);
      cmp("reset_map", map1, 0);

      frame(0, '0, '0, '0, 0, '0, 0);

      fd = rep_d(11'h7FF);
      fd[5*K +: K] = 11'h7EF;
      frame(0, fd, rep_h(4'hF), rep_d(11'h7FF), 1, 24'h000020, 1);

      fh = rep_h(4'hF);
      fh[0 +: R] = 4'hB;
      frame(0, rep_d(11'h7FF), fh, rep_d(11'h7FF), 1, 24'h000001, 0);

      fd = rep_d(11'h7FF);
      for (int b = 0; b < NBLK; b++) fd[b*K + (b % K)] = 1'b0;
      frame(0, fd, rep_h(4'hF), rep_d(11'h7FF), 24, 24'hFFFFFF, 0);

      fd = '0; fh = '0; fe = '0;
      fh[0 +: R] = 4'h3;        fe[0 +: K] = 11'h001;
      fh[R +: R] = 4'hF;        fe[K +: K] = 11'h400;
      fd[2*K +: K] = 11'h7FC; fh[2*R +: R] = 4'hF; fe[2*K +: K] = 11'h7F8;
      fm = 24'h000007;
      frame(0, fd, fh, fe, 3, fm, 0);

      din = rep_d(11'h7FF);
      hin = rep_h(4'hF);
      start1 = 1;
      @(negedge clk);
      start1 = 0;
      repeat (11) @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      cmp("abort_busy", busy1, 0);
      cmp("abort_done", done1, 0);
      cmp("abort_data", od1, 0);
      cmp("abort_cnt", cnt1, 0);
      cmp("abort_map", map1, 0);
      repeat (30) @(negedge clk);

      fd = rep_d(11'h7FF);
      fd[5*K +: K] = 11'h7EF;
      frame(1, fd, rep_h(4'hF), rep_d(11'h7FF), 1, 24'h000020, 0);

      repeat (5) @(negedge clk);
      cmp("pending_l1", q1.size(), 0);
      cmp("pending_l4", q4.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
